// File: rtl/sub25_norm_seq.sv
// Multi-cycle mantissa subtractor/normalizer: |a-b| with sign, left-normalized
// one bit per cycle, reporting the shift count for exponent adjustment.
module sub25_norm_seq #(
  parameter int W       = 25,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_mant,
  output logic [SHIFT_W-1:0] out_shift,
  output logic               out_sign,
  output logic               out_zero,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_NORM, S_DONE} state_t;

  localparam logic [W-1:0]       ONE_W  = W'(1);
  localparam logic [SHIFT_W-1:0] ONE_SH = SHIFT_W'(1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [W-1:0]       mant_q, mant_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic               sign_q, sign_d;
  logic               zero_q, zero_d;

  logic [W:0]         sum;
  logic [W-1:0]       diff;

  // a + ~b + 1 over W+1 bits; a clear carry-out means a<b, so negate to get b-a
  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};
    diff = sum[W] ? sum[W-1:0] : (~sum[W-1:0] + ONE_W);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mant_d  = mant_q;
    shift_d = shift_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        shift_d = '0;
        if (diff == '0) begin
          mant_d  = '0;
          sign_d  = 1'b0;
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          mant_d  = diff;
          sign_d  = ~sum[W];
          zero_d  = 1'b0;
          state_d = diff[W-1] ? S_DONE : S_NORM;
        end
      end
      S_NORM: begin
        mant_d  = {mant_q[W-2:0], 1'b0};
        shift_d = shift_q + ONE_SH;
        // mant is non-zero here, so the shift stops at W-1 at most
        if (mant_q[W-2]) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mant_q  <= '0;
      shift_q <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mant_q  <= mant_d;
      shift_q <= shift_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_SUB) || (state_q == S_NORM);
    out_mant  = mant_q;
    out_shift = shift_q;
    out_sign  = sign_q;
    out_zero  = zero_q;
  end

endmodule

// File: tb/tb_sub25_norm_seq.sv
// Directed table plus corner sequences and a random back-to-back run for sub25_norm_seq.
module tb_sub25_norm_seq;

  localparam int W = 25;
  localparam int SHIFT_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       a, b;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_mant;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_sign, out_zero, busy;

  sub25_norm_seq #(.W(W), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_shift(out_shift), .out_sign(out_sign),
    .out_zero(out_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mant;
    int           shift;
    logic         sign;
    logic         zero;
    int           lat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands in IDLE, then count cycles until out_valid (accept edge ends cycle 0).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    a = ia; b = ib; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ia; b = ~ib;
    lat = 1;
    @(negedge clk);
    chk("busy_in_sub", {31'd0, busy}, 32'd1);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Handshake the result and confirm no same-cycle re-accept.
  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_ack", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_ack", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_res(input string tag, input vec_t v, input int lat);
    chk({tag, "_mant"},  32'(out_mant), 32'(v.mant));
    chk({tag, "_shift"}, 32'(out_shift), 32'(v.shift));
    chk({tag, "_sign"},  {31'd0, out_sign}, {31'd0, v.sign});
    chk({tag, "_zero"},  {31'd0, out_zero}, {31'd0, v.zero});
    chk({tag, "_lat"},   32'(lat), 32'(v.lat));
  endtask

  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    vec_t r;
    logic [W-1:0] d;
    r.a = ma; r.b = mb;
    r.sign = (ma < mb);
    d = r.sign ? (mb - ma) : (ma - mb);
    r.zero = (d == '0);
    r.shift = 0;
    if (!r.zero) begin
      while (!d[W-1]) begin
        d = d << 1;
        r.shift++;
      end
    end
    r.mant = d;
    r.lat = 2 + r.shift;
    return r;
  endfunction

  vec_t tbl[9];

  initial begin
    int lat;
    logic [W-1:0] hm;
    logic [SHIFT_W-1:0] hs;
    logic hsg, hz;
    vec_t v;

    tbl[0] = '{25'h0000005, 25'h0000003, 25'h1000000, 23, 1'b0, 1'b0, 25};
    tbl[1] = '{25'h0000003, 25'h0000005, 25'h1000000, 23, 1'b1, 1'b0, 25};
    tbl[2] = '{25'h0ABCDEF, 25'h0ABCDEF, 25'h0000000, 0,  1'b0, 1'b1, 2};
    tbl[3] = '{25'h1FFFFFF, 25'h0000000, 25'h1FFFFFF, 0,  1'b0, 1'b0, 2};
    tbl[4] = '{25'h1000000, 25'h0000001, 25'h1FFFFFE, 1,  1'b0, 1'b0, 3};
    tbl[5] = '{25'h0000001, 25'h0000000, 25'h1000000, 24, 1'b0, 1'b0, 26};
    tbl[6] = '{25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF, 0,  1'b1, 1'b0, 2};
    tbl[7] = '{25'h0000000, 25'h0000000, 25'h0000000, 0,  1'b0, 1'b1, 2};
    tbl[8] = '{25'h0123456, 25'h0023456, 25'h1000000, 4,  1'b0, 1'b0, 6};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_mant",      32'(out_mant), 32'd0);
    chk("rst_shift",     32'(out_shift), 32'd0);
    chk("rst_sign_zero", {30'd0, out_sign, out_zero}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, lat);
      check_res($sformatf("vec%0d", i), tbl[i], lat);
      release_out();
    end

    // Backpressure: result held, new operands ignored while DONE.
    run_op(25'h0000005, 25'h0000003, lat);
    hm = out_mant; hs = out_shift; hsg = out_sign; hz = out_zero;
    chk("bp_mant0", 32'(hm), 32'h1000000);
    in_valid = 1'b1; a = 25'h1FFFFFF; b = 25'h0000001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("bp_mant",      32'(out_mant), 32'h1000000);
      chk("bp_shift",     32'(out_shift), 32'd23);
      chk("bp_sign_zero", {30'd0, out_sign, out_zero}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("idle_hold_mant",  32'(out_mant), 32'(hm));
    chk("idle_hold_shift", 32'(out_shift), 32'(hs));
    chk("idle_hold_flags", {30'd0, out_sign, out_zero}, {30'd0, hsg, hz});

    // Reset abort during NORM.
    @(negedge clk);
    a = 25'h0000003; b = 25'h0000005; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("norm_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy",      {31'd0, busy}, 32'd0);
    chk("abort_mant",      32'(out_mant), 32'd0);
    chk("abort_shift",     32'(out_shift), 32'd0);
    chk("abort_sign_zero", {30'd0, out_sign, out_zero}, 32'd0);
    repeat (30) begin
      @(negedge clk);
      if (out_valid) chk("abort_no_result", 32'd1, 32'd0);
    end

    // Back-to-back random operations against the reference model.
    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      if (i % 3 == 0)      rb = ra + W'($urandom_range(0, 15));
      else if (i % 3 == 1) rb = ra ^ (W'($urandom) >> $urandom_range(0, 24));
      else                 rb = W'($urandom) >> $urandom_range(0, 24);
      v = model(ra, rb);
      run_op(ra, rb, lat);
      check_res($sformatf("rnd%0d", i), v, lat);
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
